// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: operand/result handshake bundle
// for the sequential shift-add multiplier.
interface shift_add_mult_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sgn;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] q;
  logic               busy;

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, q, busy
  );

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, q, busy
  );
endinterface

// File: rtl/shift_add_mult.sv
// shift_add_mult: one multiplier bit per cycle,
// magnitude datapath with a final sign fix-up.
module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  shift_add_mult_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    q_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;

  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic             accept;
  logic             last;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Operand magnitudes; -2^(W-1) maps to 2^(W-1) as unsigned.
  always_comb begin
    mag_a = bus.a;
    mag_b = bus.b;
    if (bus.sgn && bus.a[WIDTH-1]) mag_a = -bus.a;
    if (bus.sgn && bus.b[WIDTH-1]) mag_b = -bus.b;
  end

  // Partial-product add for the current multiplier bit.
  always_comb begin
    acc_sum = acc_q;
    if (mplier_q[0]) acc_sum = acc_q + mcand_q;
    last = (cnt_q == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_ready & bus.in_valid;

  // Datapath: load on accept, shift-add in CALC,
  // latch the signed-corrected product on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      q_q      <= '0;
    end else if (accept) begin
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      mplier_q <= mag_b;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= bus.sgn
                & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end else if (busy) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last) begin
        q_q <= sign_q ? -acc_sum : acc_sum;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.q         = q_q;

endmodule
